// File: rtl/spi_mosi_burst_tx_if.sv
// spi_mosi_burst_tx_if: burst request bus and SPI pin bundle between the display sequencer and the burst engine.
interface spi_mosi_burst_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic                   i_START;
    logic [WIDTH*DEPTH-1:0] i_DATA;
    logic [DEPTH-1:0]       i_DC;
    logic [CNT_W-1:0]       i_N_transmit;
    logic                   o_MOSI;
    logic                   o_SCLK;
    logic                   o_CS;
    logic                   o_DC;
    logic                   o_BUSY;
    logic                   o_DONE;
    logic                   o_FINAL_WORD;
    modport master (
        output i_START, i_DATA, i_DC, i_N_transmit,
        input  o_MOSI, o_SCLK, o_CS, o_DC, o_BUSY, o_DONE, o_FINAL_WORD
    );
    modport slave (
        input  i_START, i_DATA, i_DC, i_N_transmit,
        output o_MOSI, o_SCLK, o_CS, o_DC, o_BUSY, o_DONE, o_FINAL_WORD
    );
endinterface

// File: rtl/spi_mosi_burst_tx.sv
// spi_mosi_burst_tx: snapshots up to DEPTH words and shifts them MSB-first as one SPI mode-0 burst.
// Define SPI_BURST_CS_GAP_EN to raise CS for CS_GAP cycles between consecutive words.
module spi_mosi_burst_tx #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 8,
    parameter int CLKS_PER_HALF = 1,
    parameter int CS_GAP        = 2,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input logic i_SCK,
    input logic i_RST,
    spi_mosi_burst_tx_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = $clog2(2 * CLKS_PER_HALF) > 0 ? $clog2(2 * CLKS_PER_HALF) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd3;
`ifdef SPI_BURST_CS_GAP_EN
    localparam logic [1:0] GAP = 2'd2;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    logic [GW-1:0] gap_q, gap_d;
`endif
    logic [1:0]             state_q, state_d;
    logic [WIDTH*DEPTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]       dc_q, dc_d;
    logic [CNT_W-1:0]       n_q, n_d, word_q, word_d, n_eff;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   shift, div_last, start_ok;
    logic [WIDTH*DEPTH-1:0] word_bits;
    logic [WIDTH-1:0]       cur_word, cur_shift;
    logic [DEPTH-1:0]       dc_shift;
    assign shift     = state_q == SHIFT;
    assign div_last  = div_q == DW'(2 * CLKS_PER_HALF - 1);
    assign start_ok  = bus.i_START && (state_q == IDLE || state_q == DONE);
    assign n_eff     = (bus.i_N_transmit > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.i_N_transmit;
    assign word_bits = data_q >> (int'(word_q) * WIDTH);
    assign cur_word  = word_bits[WIDTH-1:0];
    assign cur_shift = cur_word >> bit_q;
    assign dc_shift  = dc_q >> word_q;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dc_d    = dc_q;
        n_d     = n_q;
        word_d  = word_q;
        bit_d   = bit_q;
        div_d   = div_q;
`ifdef SPI_BURST_CS_GAP_EN
        gap_d   = gap_q;
`endif
        if (shift) begin
            div_d = div_last ? '0 : div_q + DW'(1);
            if (div_last && bit_q != '0)
                bit_d = bit_q - BW'(1);
            else if (div_last && word_q == n_q - CNT_W'(1))
                state_d = DONE;
            else if (div_last) begin
                word_d = word_q + CNT_W'(1);
                bit_d  = BW'(WIDTH - 1);
`ifdef SPI_BURST_CS_GAP_EN
                state_d = GAP;
                gap_d   = '0;
`endif
            end
`ifdef SPI_BURST_CS_GAP_EN
        end else if (state_q == GAP) begin
            gap_d   = gap_q + GW'(1);
            state_d = (gap_q == GW'(CS_GAP - 1)) ? SHIFT : GAP;
`endif
        end else begin
            state_d = IDLE;
            if (start_ok) begin
                data_d  = bus.i_DATA;
                dc_d    = bus.i_DC;
                n_d     = n_eff;
                word_d  = '0;
                bit_d   = BW'(WIDTH - 1);
                div_d   = '0;
                state_d = (n_eff == '0) ? DONE : SHIFT;
            end
        end
    end
    always_ff @(posedge i_SCK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            dc_q    <= '0;
            n_q     <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
`ifdef SPI_BURST_CS_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            n_q     <= n_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
`ifdef SPI_BURST_CS_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end
    // Outputs decode straight from state so an async reset forces them instantly.
    assign bus.o_CS         = !shift;
    assign bus.o_SCLK       = shift && (div_q >= DW'(CLKS_PER_HALF));
    assign bus.o_MOSI       = shift && cur_shift[0];
    assign bus.o_DC         = shift && dc_shift[0];
    assign bus.o_DONE       = state_q == DONE;
    assign bus.o_FINAL_WORD = shift && word_q == n_q - CNT_W'(1);
`ifdef SPI_BURST_CS_GAP_EN
    assign bus.o_BUSY = shift || state_q == GAP;
`else
    assign bus.o_BUSY = shift;
`endif
endmodule
